// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 16x oversampled, LSB first, one-hot FSM
// Frame: start bit, NB_DATA data bits, SB_TICK-tick stop; o_tx is registered for a glitch-free line.
module uart_tx #(
   parameter int NB_DATA = 8,
   parameter int SB_TICK = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_data_tx,
   output logic               o_tx,
   output logic               o_tx_done,
   output logic               o_tx_busy
);

   localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(15);
   localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } state_e;

   state_e             state_q, state_d;
   logic [TW-1:0]      tick_q, tick_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic               start_prev_q;
   logic               start_edge;

   assign start_edge = i_tx_start & ~start_prev_q;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         tx_q         <= 1'b1;
         done_q       <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         done_q       <= done_d;
         start_prev_q <= i_tx_start;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d = START;
               tick_d  = '0;
            end
         end
         START: begin
            if (i_tick) begin
               if (tick_q == TICK_LAST) begin
                  // Data is captured only here so it may settle after the start edge.
                  state_d = DATA;
                  tick_d  = '0;
                  bit_d   = '0;
                  shift_d = i_data_tx;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shift_d = shift_q >> 1;
                  if (bit_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (tick_q == STOP_LAST) begin
                  state_d = IDLE;
                  tick_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign o_tx      = tx_q;
   assign o_tx_done = done_q;
   assign o_tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a frame-level reference model
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_tick;
   logic       i_tx_start;
   logic [7:0] i_data_tx;
   logic       o_tx;
   logic       o_tx_done;
   logic       o_tx_busy;

   int checks = 0;
   int errors = 0;

   uart_tx #(.NB_DATA(8), .SB_TICK(16)) dut (
      .i_clock    (clk),
      .i_reset    (i_reset),
      .i_tick     (i_tick),
      .i_tx_start (i_tx_start),
      .i_data_tx  (i_data_tx),
      .o_tx       (o_tx),
      .o_tx_done  (o_tx_done),
      .o_tx_busy  (o_tx_busy)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic t);
      i_tick = t;
      @(posedge clk);
      #1;
      i_tick = 1'b0;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      i_reset = 1'b0;
      cyc(1'b0);
   endtask

   // Expected line level for every tick of a frame: 16 ticks per segment, segments are
   // start(0), data bits LSB first, stop(1). Data is whatever is present at the 16th tick.
   task automatic run_frame(input string name, input logic [7:0] d0, input logic [7:0] d1,
                            input int change_at, input int period, input bit hold_start,
                            input int pulse_at, input int abort_at, input bit b2b);
      logic [7:0] sent;
      logic [9:0] lv;
      int         bad;
      sent = (change_at >= 0 && change_at <= 15) ? d1 : d0;
      lv[0] = 1'b0;
      for (int i = 0; i < 8; i++) lv[i+1] = sent[i];
      lv[9] = 1'b1;
      i_data_tx  = d0;
      i_tx_start = 1'b1;
      cyc(1'b0);
      if (!hold_start) i_tx_start = 1'b0;
      checks++;
      if (o_tx_busy !== 1'b1 || o_tx !== 1'b0) begin
         errors++;
         $display("FAIL %s launch: busy=%b tx=%b expected busy=1 tx=0", name, o_tx_busy, o_tx);
      end
      for (int t = 0; t < 160; t++) begin
         if (t == change_at) i_data_tx = d1;
         if (t == abort_at) begin
            #2;
            i_reset = 1'b1;
            #1;
            checks++;
            if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) begin
               errors++;
               $display("FAIL %s async_abort: tx=%b busy=%b done=%b expected 1 0 0",
                        name, o_tx, o_tx_busy, o_tx_done);
            end
            bad = 0;
            for (int k = 0; k < 3; k++) begin
               cyc(1'b1);
               if (o_tx_done !== 1'b0 || o_tx !== 1'b1) bad++;
            end
            i_reset = 1'b0;
            for (int k = 0; k < 20; k++) begin
               cyc(1'b1);
               if (o_tx_done !== 1'b0 || o_tx !== 1'b1 || o_tx_busy !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
               errors++;
               $display("FAIL %s post_abort: %0d bad samples, required 0", name, bad);
            end
            return;
         end
         checks++;
         if (o_tx !== lv[t/16] || o_tx_done !== 1'b0 || o_tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s tick %0d: tx=%b done=%b busy=%b expected tx=%b done=0 busy=1",
                     name, t, o_tx, o_tx_done, o_tx_busy, lv[t/16]);
         end
         if (t == pulse_at) begin
            i_tx_start = 1'b1;
            cyc(1'b0);
            i_tx_start = 1'b0;
         end
         for (int k = 0; k < period - 1; k++) cyc(1'b0);
         cyc(1'b1);
      end
      checks++;
      if (o_tx_done !== 1'b1 || o_tx_busy !== 1'b0 || o_tx !== 1'b1) begin
         errors++;
         $display("FAIL %s end_of_frame: done=%b busy=%b tx=%b expected 1 0 1",
                  name, o_tx_done, o_tx_busy, o_tx);
      end
      if (hold_start) begin
         bad = 0;
         for (int k = 0; k < 5; k++) begin
            cyc(1'b0);
            if (o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
         end
         i_tx_start = 1'b0;
         for (int k = 0; k < 40; k++) begin
            cyc(1'b1);
            if (o_tx_busy !== 1'b0 || o_tx !== 1'b1 || o_tx_done !== 1'b0) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s held_start_relaunch: %0d bad samples, required 0", name, bad);
         end
      end else if (!b2b) begin
         cyc(1'b0);
         checks++;
         if (o_tx_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%b expected 0", name, o_tx_done);
         end
      end
   endtask

   task automatic test_reset();
      i_reset    = 1'b1;
      i_tick     = 1'b0;
      i_tx_start = 1'b0;
      i_data_tx  = 8'h00;
      #1;
      checks++;
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: tx=%b busy=%b done=%b expected 1 0 0", o_tx, o_tx_busy, o_tx_done);
      end
      cyc(1'b1);
      cyc(1'b1);
      i_reset = 1'b0;
      cyc(1'b1);
      checks++;
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: tx=%b busy=%b expected 1 0", o_tx, o_tx_busy);
      end
   endtask

   task automatic test_frame_55();
      run_frame("frame_55", 8'h55, 8'h55, -1, 4, 1'b0, -1, -1, 1'b0);
   endtask

   task automatic test_random_frames();
      logic [7:0] d;
      int         p;
      for (int n = 0; n < 6; n++) begin
         d = 8'($urandom);
         p = $urandom_range(1, 4);
         run_frame("random", d, d, -1, p, 1'b0, -1, -1, 1'b0);
      end
   endtask

   task automatic test_late_data();
      run_frame("late_data", 8'h00, 8'hA3, 10, 2, 1'b0, -1, -1, 1'b0);
   endtask

   task automatic test_hold_start();
      run_frame("hold_start", 8'($urandom), 8'h00, -1, 3, 1'b1, -1, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      d = 8'($urandom);
      run_frame("b2b_first", 8'hC6, 8'hC6, -1, 2, 1'b0, 16*4 + 5, -1, 1'b1);
      run_frame("b2b_second", d, d, -1, 1, 1'b0, -1, -1, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'($urandom);
      run_frame("reset_mid", 8'hFF, 8'hFF, -1, 3, 1'b0, -1, 16*6 + 4, 1'b0);
      run_frame("after_reset", d, d, -1, 2, 1'b0, -1, -1, 1'b0);
   endtask

   task automatic test_no_tick();
      int bad;
      bad = 0;
      i_data_tx  = 8'h01;
      i_tx_start = 1'b1;
      cyc(1'b0);
      i_tx_start = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         cyc(1'b0);
         if (o_tx !== 1'b0 || o_tx_busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL no_tick_hold: %0d bad samples, required 0", bad);
      end
      for (int k = 0; k < 15; k++) cyc(1'b1);
      checks++;
      if (o_tx !== 1'b0) begin
         errors++;
         $display("FAIL no_tick_15th: tx=%b expected 0", o_tx);
      end
      cyc(1'b1);
      checks++;
      if (o_tx !== 1'b1) begin
         errors++;
         $display("FAIL no_tick_16th: tx=%b expected 1", o_tx);
      end
      do_reset();
   endtask

   task automatic test_reset_start_high();
      i_reset    = 1'b1;
      i_tx_start = 1'b1;
      cyc(1'b0);
      i_reset = 1'b0;
      cyc(1'b0);
      checks++;
      if (o_tx_busy !== 1'b1 || o_tx !== 1'b0) begin
         errors++;
         $display("FAIL start_at_release: busy=%b tx=%b expected 1 0", o_tx_busy, o_tx);
      end
      i_tx_start = 1'b0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_frame_55();
      test_random_frames();
      test_late_data();
      test_hold_start();
      test_back_to_back();
      test_reset_mid();
      test_no_tick();
      test_reset_start_high();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: stop-bit length in ticks (16 = 1 stop bit).
REQ-003 SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port i_tick, input, 1 bit: one-cycle pulse at 16x baud rate from the baud generator.
REQ-006 SHALL have port i_tx_start, input, 1 bit: launch request; only its rising edge is significant.
REQ-007 SHALL have port i_data_tx, input, NB_DATA bits: byte to transmit.
REQ-008 SHALL have port o_tx, output, 1 bit: serial line; idle high.
REQ-009 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse at end of frame.
REQ-010 SHALL have port o_tx_busy, output, 1 bit: high while state is not IDLE.

Function
REQ-011 SHALL implement a one-hot 4-bit FSM with states IDLE=0001, START=0010, DATA=0100, STOP=1000; illegal codes go to IDLE.
REQ-012 SHALL register i_tx_start every clock (start_prev); a start edge is i_tx_start=1 and start_prev=0.
REQ-013 SHALL, in IDLE on a start edge, go to START with tick counter=0, independent of i_tick.
REQ-014 SHALL ignore start edges while not IDLE and SHALL NOT relaunch on a level held high after o_tx_done.
REQ-015 SHALL, in START, hold o_tx=0; on each i_tick, increment the tick counter; on the tick where the counter=15, go to DATA, clear both the tick and bit counters, and load the shift register from i_data_tx.
REQ-016 SHALL sample i_data_tx only at the START-to-DATA transition (16 ticks after the edge), so data may settle after the start edge.
REQ-017 SHALL, in DATA, drive o_tx=shift register bit 0 (LSB first); on each i_tick with counter=15, clear the counter and shift right one bit; when the bit counter=NB_DATA-1, go to STOP, otherwise increment the bit counter.
REQ-018 SHALL, in STOP, hold o_tx=1; on the tick where the counter=SB_TICK-1, go to IDLE and assert o_tx_done for exactly that one clock.
REQ-019 SHALL drive o_tx from a register updated with the state, so it is glitch-free; the bit counter width is clog2(NB_DATA).
REQ-020 SHALL advance counters only on clocks with i_tick=1; without ticks the FSM holds its state indefinitely.
REQ-021 SHALL make a default frame last exactly 160 ticks: 16 start, 8x16 data, 16 stop.
REQ-022 SHALL accept a new start edge on the clock after o_tx_done, giving back-to-back frames with no idle tick required.

Reset
REQ-023 SHALL, while i_reset=1, immediately force state=IDLE, o_tx=1, o_tx_done=0, o_tx_busy=0, all counters=0, shift register=0, start_prev=0.
REQ-024 SHALL, on reset mid-frame, abort the frame and return the line high at once, with no o_tx_done pulse.
REQ-025 SHALL treat i_tx_start=1 at reset release as a start edge, because start_prev=0.

Verification
REQ-026 Pulse start with i_data_tx=0x55 and ticks every 4 clocks -> o_tx reads 0, 1,0,1,0,1,0,1,0, then 1, each level lasting 16 ticks; a single o_tx_done pulse follows after 160 ticks.
REQ-027 Raise start, hold i_data_tx=0x00 for 10 ticks, then set it to 0xA3 -> 0xA3 is transmitted as data bits 1,1,0,0,0,1,0,1.
REQ-028 Hold start high before, through, and 5 clocks after o_tx_done -> exactly one frame is sent, and o_tx_busy=0 after done.
REQ-029 Send a second start pulse during DATA bit 3, then another on the clock after done -> the first is ignored and the second begins a new frame immediately.
REQ-030 Assert reset during DATA bit 5 -> o_tx=1 and o_tx_busy=0 without waiting for a clock edge, with no done pulse; the next start edge sends a full frame.
REQ-031 Raise start with i_tick held 0 for 1000 clocks -> the FSM stays in START with o_tx=0 and the counter stays at 0.
